step_map_grid: RTL and testbench

STEP_MAP_GRID -- requirements
Module: step_map_grid

---
 rtl/step_map_grid.sv | 162 ++++++++++++++++
 tb/tb_step_map_grid.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_map_grid.sv
// Tile map for a VGA step grid: pixel-to-tile lookup with registered outputs,
// a cell write port, a blinking SPIKE type and a one-cell-per-cycle clear engine.
module step_map_grid #(
    parameter int unsigned TILE_W       = 64,
    parameter int unsigned TILE_H       = 68,
    parameter int unsigned NUM_OF_COLS  = 10,
    parameter int unsigned NUM_OF_ROWS  = 7,
    parameter int unsigned SPIKE_PERIOD = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        wr_en,
    input  logic [3:0]  wr_col,
    input  logic [2:0]  wr_row,
    input  logic [2:0]  wr_type,
    input  logic        clear_req,
    output logic [10:0] tileTopLeftX,
    output logic [10:0] tileTopLeftY,
    output logic [2:0]  step_type,
    output logic        clear_busy
);

    localparam int unsigned X_SH  = $clog2(TILE_W);
    localparam int unsigned COL_W = $clog2(NUM_OF_COLS);
    localparam int unsigned ROW_W = $clog2(NUM_OF_ROWS);
    localparam int unsigned FC_W  = $clog2(SPIKE_PERIOD);
    localparam logic [2:0]  FREE  = 3'd0;
    localparam logic [2:0]  SPIKE = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_CLEARING = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_cells [NUM_OF_ROWS][NUM_OF_COLS];
    logic [ROW_W-1:0]   r_clr_row;
    logic [COL_W-1:0]   r_clr_col;
    logic [FC_W-1:0]    r_frame_cnt;
    logic               r_spikes_visible;
    logic [10:0]        r_tlx;
    logic [10:0]        r_tly;
    logic [2:0]         r_type;
    logic               r_busy;

    logic [10:0]        w_col;
    logic               w_col_ok;
    logic [ROW_W-1:0]   w_row;
    logic               w_row_ok;
    logic [10:0]        w_tly;
    logic               w_hit;
    logic [2:0]         w_cell;
    logic [2:0]         w_type;
    logic               w_clr_last;
    logic               w_wr_accept;

    assign w_col    = pixelX >> X_SH;
    assign w_col_ok = (w_col < 11'(NUM_OF_COLS));

    // Row found by range compare against multiples of TILE_H; no divider.
    always_comb begin
        w_row    = '0;
        w_row_ok = 1'b0;
        w_tly    = '0;
        for (int unsigned r = 0; r < NUM_OF_ROWS; r++) begin
            if (pixelY >= 11'(r * TILE_H) && pixelY < 11'((r + 1) * TILE_H)) begin
                w_row    = ROW_W'(r);
                w_row_ok = 1'b1;
                w_tly    = 11'(r * TILE_H);
            end
        end
    end

    assign w_hit  = w_col_ok && w_row_ok;
    assign w_cell = w_hit ? r_cells[w_row][w_col[COL_W-1:0]] : FREE;
    assign w_type = (w_cell == SPIKE && !r_spikes_visible) ? FREE : w_cell;

    assign w_clr_last  = (r_clr_row == ROW_W'(NUM_OF_ROWS - 1)) &&
                         (r_clr_col == COL_W'(NUM_OF_COLS - 1));
    assign w_wr_accept = (r_state == S_IDLE) && wr_en && !clear_req &&
                         (wr_col < 4'(NUM_OF_COLS)) && (wr_row < 3'(NUM_OF_ROWS));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (clear_req)  w_state_nxt = S_CLEARING;
            S_CLEARING: if (w_clr_last) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_clr_row <= '0;
            r_clr_col <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_CLEARING);
            if (r_state == S_CLEARING) begin
                if (r_clr_col == COL_W'(NUM_OF_COLS - 1)) begin
                    r_clr_col <= '0;
                    r_clr_row <= w_clr_last ? '0 : r_clr_row + 1'b1;
                end else begin
                    r_clr_col <= r_clr_col + 1'b1;
                end
            end
        end
    end

    // Clear engine owns the array while active; host writes only land in IDLE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int r = 0; r < int'(NUM_OF_ROWS); r++) begin
                for (int c = 0; c < int'(NUM_OF_COLS); c++) begin
                    r_cells[r][c] <= FREE;
                end
            end
        end else if (r_state == S_CLEARING) begin
            r_cells[r_clr_row][r_clr_col] <= FREE;
        end else if (w_wr_accept) begin
            r_cells[ROW_W'(wr_row)][COL_W'(wr_col)] <= wr_type;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_cnt      <= '0;
            r_spikes_visible <= 1'b1;
        end else if (startOfFrame) begin
            if (r_frame_cnt == FC_W'(SPIKE_PERIOD - 1)) begin
                r_frame_cnt      <= '0;
                r_spikes_visible <= !r_spikes_visible;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_tlx  <= '0;
            r_tly  <= '0;
            r_type <= FREE;
        end else begin
            r_tlx  <= w_hit ? 11'(w_col << X_SH) : '0;
            r_tly  <= w_hit ? w_tly : '0;
            r_type <= w_type;
        end
    end

    assign tileTopLeftX = r_tlx;
    assign tileTopLeftY = r_tly;
    assign step_type    = r_type;
    assign clear_busy   = r_busy;

endmodule

// File: tb/tb_step_map_grid.sv
// Randomized self-checking bench for step_map_grid against a cycle-level
// reference model built from division/modulo arithmetic on a plain array.
module tb_step_map_grid;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_col = '0;
    logic [2:0]  wr_row = '0;
    logic [2:0]  wr_type = '0;
    logic        clear_req = 1'b0;
    logic [10:0] tileTopLeftX;
    logic [10:0] tileTopLeftY;
    logic [2:0]  step_type;
    logic        clear_busy;

    step_map_grid dut (
        .clk          (clk),
        .resetN       (resetN),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_type      (wr_type),
        .clear_req    (clear_req),
        .tileTopLeftX (tileTopLeftX),
        .tileTopLeftY (tileTopLeftY),
        .step_type    (step_type),
        .clear_busy   (clear_busy)
    );

    always #5 clk = ~clk;

    int m_cell [7][10];
    bit m_vis;
    int m_fc;
    bit m_clr;
    int m_idx;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 10; c++)
                m_cell[r][c] = 0;
        m_vis = 1'b1;
        m_fc  = 0;
        m_clr = 1'b0;
        m_idx = 0;
    endtask

    // One clock: drive inputs, predict from pre-edge model, advance model, compare.
    task automatic step(input int x, input int y, input bit sof, input bit we,
                        input int wc, input int wr, input int wt, input bit clr);
        int col, row, ex, ey, et;
        pixelX       = 11'(x);
        pixelY       = 11'(y);
        startOfFrame = sof;
        wr_en        = we;
        wr_col       = 4'(wc);
        wr_row       = 3'(wr);
        wr_type      = 3'(wt);
        clear_req    = clr;
        col = x / 64;
        row = y / 68;
        if (col < 10 && row < 7) begin
            ex = col * 64;
            ey = row * 68;
            et = m_cell[row][col];
            if (et == 5 && !m_vis) et = 0;
        end else begin
            ex = 0; ey = 0; et = 0;
        end
        @(posedge clk);
        #1;
        if (m_clr) begin
            m_cell[m_idx / 10][m_idx % 10] = 0;
            m_idx++;
            if (m_idx == 70) begin
                m_clr = 1'b0;
                m_idx = 0;
            end
        end else if (clr) begin
            m_clr = 1'b1;
            m_idx = 0;
        end else if (we && wc < 10 && wr < 7) begin
            m_cell[wr][wc] = wt;
        end
        if (sof) begin
            if (m_fc == 29) begin
                m_fc  = 0;
                m_vis = !m_vis;
            end else begin
                m_fc++;
            end
        end
        chk("tlx", 32'(tileTopLeftX), 32'(ex));
        chk("tly", 32'(tileTopLeftY), 32'(ey));
        chk("type", 32'(step_type), 32'(et));
        chk("busy", 32'(clear_busy), 32'(m_clr));
        startOfFrame = 1'b0;
        wr_en        = 1'b0;
        clear_req    = 1'b0;
    endtask

    task automatic look(input int x, input int y);
        step(x, y, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int c, input int r, input int t);
        step($urandom_range(0, 700), $urandom_range(0, 520), 1'b0, 1'b1, c, r, t, 1'b0);
    endtask

    task automatic sweep(input bit expect_free);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 10; c++) begin
                look(c * 64 + $urandom_range(0, 63), r * 68 + $urandom_range(0, 67));
                if (expect_free) chk("sweep_free", 32'(step_type), 32'd0);
            end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tlx"}, 32'(tileTopLeftX), 32'd0);
        chk({tag, "_tly"}, 32'(tileTopLeftY), 32'd0);
        chk({tag, "_type"}, 32'(step_type), 32'd0);
        chk({tag, "_busy"}, 32'(clear_busy), 32'd0);
    endtask

    initial begin
        int n_busy;
        int guard;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        resetN = 1'b1;

        // Directed lookups, including grid corner and just-outside row.
        wr(3, 2, 5);
        look(200, 150);
        chk("dir_x", 32'(tileTopLeftX), 32'd192);
        chk("dir_y", 32'(tileTopLeftY), 32'd136);
        chk("dir_t", 32'(step_type), 32'd5);
        wr(9, 6, 3);
        look(639, 475);
        chk("corner_x", 32'(tileTopLeftX), 32'd576);
        chk("corner_y", 32'(tileTopLeftY), 32'd408);
        chk("corner_t", 32'(step_type), 32'd3);
        look(100, 476);
        chk("out_y_t", 32'(step_type), 32'd0);
        look(640, 10);
        chk("out_x_x", 32'(tileTopLeftX), 32'd0);

        // Write then same-cycle lookup returns old contents.
        step(200, 150, 1'b0, 1'b1, 3, 2, 1, 1'b0);
        wr(3, 2, 5);

        // Spike blink over two half-periods.
        for (int i = 0; i < 30; i++) step(200, 150, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        look(200, 150);
        chk("spike_off", 32'(step_type), 32'd0);
        for (int i = 0; i < 30; i++) step(200, 150, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        look(200, 150);
        chk("spike_on", 32'(step_type), 32'd5);

        // Out-of-range writes must change nothing.
        wr(10, 0, 4);
        wr(3, 7, 4);
        wr(15, 7, 4);
        sweep(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 700), $urandom_range(0, 520),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 5),
                 ($urandom_range(0, 149) == 0));
        guard = 0;
        while (m_clr && guard < 100) begin
            look($urandom_range(0, 700), $urandom_range(0, 520));
            guard++;
        end

        // Full clear with a colliding write, ignored writes during clear.
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 10; c++) wr(c, r, 1);
        n_busy = 0;
        step(639, 475, 1'b0, 1'b1, 9, 6, 4, 1'b1);
        if (clear_busy) n_busy++;
        guard = 0;
        while (clear_busy && guard < 200) begin
            if (guard % 4 == 0)
                step(639, 475, 1'b0, 1'b1, 9, 6, 4, 1'b1);
            else
                step($urandom_range(0, 700), $urandom_range(0, 520), 1'b0, 1'b1,
                     $urandom_range(0, 9), $urandom_range(0, 6), 4, 1'b1);
            if (clear_busy) n_busy++;
            guard++;
        end
        chk("clear_len", 32'(n_busy), 32'd70);
        sweep(1'b1);

        // Reset in the middle of a clear.
        for (int i = 0; i < 30; i++) wr($urandom_range(0, 9), $urandom_range(0, 6), $urandom_range(1, 5));
        step(0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        for (int i = 1; i < 20; i++) look($urandom_range(0, 700), $urandom_range(0, 520));
        resetN = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        #2;
        resetN = 1'b1;
        sweep(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
